// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the whack-a-mole game sequencer:
//   - game_state_t : FSM state encoding (IDLE=0, ARM=1, PLAY=2, OVER=3)
//   - LFSR_SEED    : value the mole-position LFSR holds out of reset
//   - LFSR_TAPS    : feedback tap mask for x^8 + x^6 + x^5 + x^4 + 1
//   - lfsr_step    : one shift of the Fibonacci LFSR
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // The register shifts toward the MSB, so polynomial terms x^8, x^6, x^5
  // and x^4 map onto bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// Free-running 8-bit Fibonacci LFSR used to pick mole positions. It shifts on
// every rising clock edge whatever the game is doing. Because the polynomial
// is maximal-length and the seed is non-zero, the all-zero lock-up state is
// never reached.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset, reloads LFSR_SEED
//   out   out  current LFSR contents
// -----------------------------------------------------------------------------
module lfsr8
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= LFSR_SEED;
    end else begin
      out <= lfsr_step(out);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Whack-a-mole game control. Start moves the block through a one-cycle ARM
// state, which clears the score, into PLAY for GAME_TICKS game ticks. During
// PLAY a single mole is popped up at a pseudo-random position. The mole stays
// up for MOLE_TICKS ticks or until its button is pressed. When the game ends
// the block sits in OVER until the next start pulse.
// Parameters:
//   NUM_MOLES  number of mole positions (power of two, 2..8)
//   TICK_DIV   clk cycles per game tick
//   GAME_TICKS game length in ticks (1..255)
//   MOLE_TICKS ticks a mole stays up (1..15)
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   start        in   single-cycle start pulse (honoured in IDLE and OVER)
//   btn          in   per-mole whack pulses
//   mole         out  one-hot active mole, zero when none is up
//   score_clear  out  one-cycle score counter clear (the ARM cycle)
//   score_enable out  score counter enable, PLAY plus one trailing cycle
//   hit_pulse    out  one-cycle strobe per accepted hit
//   time_left    out  remaining game ticks
//   game_over    out  high while in OVER
// -----------------------------------------------------------------------------
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_MOLES  = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int GAME_TICKS = 30,
  parameter int MOLE_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] btn,
  output logic [NUM_MOLES-1:0] mole,
  output logic                 score_clear,
  output logic                 score_enable,
  output logic                 hit_pulse,
  output logic [7:0]           time_left,
  output logic                 game_over
);

  localparam int IDX_W   = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [7:0]         GAME_LEN   = 8'(GAME_TICKS);
  localparam logic [3:0]         MOLE_LIFE  = 4'(MOLE_TICKS);

  game_state_t state_q, state_d;

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [7:0]           time_left_d;
  logic [NUM_MOLES-1:0] mole_d;
  logic [3:0]           mole_timer_q, mole_timer_d;
  logic                 hit_pulse_d;
  logic                 score_enable_d;

  logic [7:0]           lfsr_out;
  logic [IDX_W-1:0]     spawn_idx;
  logic [NUM_MOLES-1:0] spawn_mole;
  logic                 tick;
  logic                 hit_accept;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr_out)
  );

  // NUM_MOLES is a power of two, so the modulo keeps just the low LFSR bits.
  assign spawn_idx  = IDX_W'(lfsr_out % 8'(NUM_MOLES));
  assign spawn_mole = NUM_MOLES'(1) << spawn_idx;

  assign tick       = (state_q == PLAY) && (presc_q == PRESC_LAST);
  assign hit_accept = (state_q == PLAY) && (|(btn & mole));

  assign score_clear = (state_q == ARM);
  assign game_over   = (state_q == OVER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The game-ending tick outranks everything else that could happen to the
  // mole in that cycle. After that, a hit outranks expiry. A spawn only
  // happens from an empty board, so every clear is followed by at least one
  // mole-free cycle. hit_pulse follows hit_accept in every state, which lets
  // a hit on the final tick still show up in the first OVER cycle.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    time_left_d  = time_left;
    mole_d       = mole;
    mole_timer_d = mole_timer_q;
    hit_pulse_d  = hit_accept;

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = ARM;
        end
      end

      ARM: begin
        state_d      = PLAY;
        time_left_d  = GAME_LEN;
        presc_d      = '0;
        mole_d       = '0;
        mole_timer_d = '0;
      end

      PLAY: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          time_left_d = time_left - 8'd1;
        end

        if (tick && (time_left == 8'd1)) begin
          state_d      = OVER;
          time_left_d  = '0;
          mole_d       = '0;
          mole_timer_d = '0;
        end else if (hit_accept) begin
          mole_d       = '0;
          mole_timer_d = '0;
        end else if (mole == '0) begin
          mole_d       = spawn_mole;
          mole_timer_d = MOLE_LIFE;
        end else if (tick) begin
          if (mole_timer_q == 4'd1) begin
            mole_d       = '0;
            mole_timer_d = '0;
          end else begin
            mole_timer_d = mole_timer_q - 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Looking at both the current and the next state keeps the enable high
    // from the very first PLAY cycle through one cycle after PLAY ends.
    score_enable_d = (state_q == PLAY) || (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      time_left    <= '0;
      mole         <= '0;
      mole_timer_q <= '0;
      hit_pulse    <= 1'b0;
      score_enable <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      time_left    <= time_left_d;
      mole         <= mole_d;
      mole_timer_q <= mole_timer_d;
      hit_pulse    <= hit_pulse_d;
      score_enable <= score_enable_d;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Self-checking bench for game_sequencer (TICK_DIV=4, GAME_TICKS=10,
// MOLE_TICKS=3, NUM_MOLES=4). A behavioural game model predicts every output
// each cycle. Directed points pin the model with hand-worked values: the
// reset state, game length, mole lifetime, hit handling, a hit on the final
// tick, reset mid-game and a restart from OVER.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

  localparam int NUM_MOLES  = 4;
  localparam int TICK_DIV   = 4;
  localparam int GAME_TICKS = 10;
  localparam int MOLE_TICKS = 3;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] btn;
  logic [3:0] mole;
  logic       score_clear;
  logic       score_enable;
  logic       hit_pulse;
  logic [7:0] time_left;
  logic       game_over;

  int total;
  int bad;
  bit cmp_en;
  int over_at;

  // mode: 0 idle, 1 arm, 2 play, 3 over; pos = -1 when no mole is up.
  typedef struct {
    int         mode;
    int         pos;
    int         tl;
    int         life;
    int         play_cycles;
    bit         hit;
    bit         se;
    logic [7:0] lfsr;
  } model_t;

  model_t m;

  game_sequencer #(
    .NUM_MOLES  (NUM_MOLES),
    .TICK_DIV   (TICK_DIV),
    .GAME_TICKS (GAME_TICKS),
    .MOLE_TICKS (MOLE_TICKS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .btn          (btn),
    .mole         (mole),
    .score_clear  (score_clear),
    .score_enable (score_enable),
    .hit_pulse    (hit_pulse),
    .time_left    (time_left),
    .game_over    (game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic model_t reset_model();
    model_t r;
    r.mode = 0; r.pos = -1; r.tl = 0; r.life = 0; r.play_cycles = 0;
    r.hit = 1'b0; r.se = 1'b0; r.lfsr = 8'hA5;
    return r;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [3:0] mole_of(input int pos);
    return (pos < 0) ? 4'b0000 : 4'(1 << pos);
  endfunction

  // Game rules expressed on the play-cycle count: a tick lands on every
  // TICK_DIV-th cycle of PLAY.
  function automatic model_t step(input model_t cur, input logic s, input logic [3:0] b);
    model_t n = cur;
    bit was_play, hit, tick;
    was_play = (cur.mode == 2);
    hit  = was_play && (cur.pos >= 0) && b[cur.pos[1:0]];
    tick = was_play && ((cur.play_cycles % TICK_DIV) == TICK_DIV - 1);
    n.lfsr = lfsr_next(cur.lfsr);
    n.hit  = hit;
    case (cur.mode)
      0, 3: if (s) n.mode = 1;
      1: begin
        n.mode = 2; n.play_cycles = 0; n.tl = GAME_TICKS; n.pos = -1;
      end
      default: begin
        n.play_cycles = cur.play_cycles + 1;
        if (tick) n.tl = cur.tl - 1;
        if (tick && n.tl == 0) begin
          n.mode = 3; n.pos = -1;
        end else if (hit) begin
          n.pos = -1;
        end else if (cur.pos < 0) begin
          n.pos = int'(cur.lfsr) % NUM_MOLES; n.life = MOLE_TICKS;
        end else if (tick) begin
          n.life = cur.life - 1;
          if (n.life == 0) n.pos = -1;
        end
      end
    endcase
    n.se = was_play || (n.mode == 2);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= reset_model();
    else        m <= step(m, start, btn);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // kind: 0 none, 1 matching button, 2 all buttons, 3 wrong button,
  // 4 random. Kinds 1-3 fire only at the requested play cycle with a mole up.
  task automatic applyStimulus(input logic s, input int kind, input int at_cycle);
    logic [3:0] b = 4'b0000;
    @(posedge clk);
    #1;
    if (kind == 4) begin
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
    end else if (kind != 0 && m.mode == 2 && m.play_cycles == at_cycle && m.pos >= 0) begin
      case (kind)
        1:       b = mole_of(m.pos);
        2:       b = 4'b1111;
        default: b = mole_of((m.pos + 1) % NUM_MOLES);
      endcase
    end
    start = s;
    btn   = b;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("mole",         32'(mole),         32'(mole_of(m.pos)));
      checkOutput("mole_onehot",  32'($countones(mole) <= 1), 32'd1);
      checkOutput("time_left",    32'(time_left),    32'(m.tl));
      checkOutput("score_clear",  32'(score_clear),  32'(m.mode == 1));
      checkOutput("score_enable", 32'(score_enable), 32'(m.se));
      checkOutput("hit_pulse",    32'(hit_pulse),    32'(m.hit));
      checkOutput("game_over",    32'(game_over),    32'(m.mode == 3));
    end
  end

  initial begin
    #100000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: time limit reached got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    total = 0; bad = 0; cmp_en = 1'b0;
    rst_n = 1'b0; start = 1'b0; btn = 4'b0000;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_mole",         32'(mole), 0);
    checkOutput("reset_time_left",    32'(time_left), 0);
    checkOutput("reset_game_over",    32'(game_over), 0);
    checkOutput("reset_score_enable", 32'(score_enable), 0);
    rst_n = 1'b1;

    // Game 1: no presses except a hit on the game-ending tick.
    $display("[TB] game 1: idle player, hit on final tick");
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b0, 0, 0);
    @(negedge clk);
    checkOutput("arm_score_clear", 32'(score_clear), 1);
    applyStimulus(1'b0, 0, 0);
    @(negedge clk);
    checkOutput("play_time_left",    32'(time_left), 10);
    checkOutput("play_score_enable", 32'(score_enable), 1);
    over_at = -1;
    for (int c = 1; c <= 60 && over_at < 0; c++) begin
      applyStimulus(1'b0, 1, 39);
      @(negedge clk);
      if (c == 1)  checkOutput("first_spawn_onehot", 32'($countones(mole)), 1);
      if (c == 12) checkOutput("expire_after_3_ticks", 32'(mole), 0);
      if (c == 13) checkOutput("respawn_after_gap", 32'($countones(mole)), 1);
      if (c == 40) begin
        checkOutput("final_hit_pulse",    32'(hit_pulse), 1);
        checkOutput("final_score_enable", 32'(score_enable), 1);
        checkOutput("final_time_left",    32'(time_left), 0);
      end
      if (game_over) over_at = c;
    end
    checkOutput("over_after_40", 32'(over_at), 40);
    applyStimulus(1'b0, 0, 0);
    @(negedge clk);
    checkOutput("score_enable_drop", 32'(score_enable), 0);
    checkOutput("hit_pulse_single",  32'(hit_pulse), 0);
    checkOutput("over_holds",        32'(game_over), 1);

    // Game 2: restart from OVER, directed hits, then random play.
    $display("[TB] game 2: restart from over, directed and random presses");
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b0, 0, 0);
    @(negedge clk);
    checkOutput("restart_score_clear", 32'(score_clear), 1);
    applyStimulus(1'b0, 0, 0);
    @(negedge clk);
    checkOutput("restart_time_left", 32'(time_left), 10);
    over_at = -1;
    for (int c = 1; c <= 60 && over_at < 0; c++) begin
      if (c == 3)       applyStimulus(1'b0, 1, 3);
      else if (c == 7)  applyStimulus(1'b0, 2, 7);
      else if (c == 11) applyStimulus(1'b0, 3, 11);
      else if (c >= 13) applyStimulus((c <= 38) && ($urandom_range(0, 7) == 0), 4, 0);
      else              applyStimulus(1'b0, 0, 0);
      @(negedge clk);
      if (c == 4) begin
        checkOutput("hit_pulse_on_match",     32'(hit_pulse), 1);
        checkOutput("mole_cleared_after_hit", 32'(mole), 0);
      end
      if (c == 5) begin
        checkOutput("hit_pulse_one_cycle", 32'(hit_pulse), 0);
        checkOutput("new_mole_onehot",     32'($countones(mole)), 1);
      end
      if (c == 8)  checkOutput("all_buttons_one_hit",   32'(hit_pulse), 1);
      if (c == 9)  checkOutput("all_buttons_no_second", 32'(hit_pulse), 0);
      if (c == 12) begin
        checkOutput("wrong_button_ignored",    32'(hit_pulse), 0);
        checkOutput("wrong_button_mole_stays", 32'($countones(mole)), 1);
      end
      if (game_over) over_at = c;
    end
    checkOutput("game2_over_40", 32'(over_at), 40);

    // Game 3: abort with reset in the middle of PLAY.
    $display("[TB] game 3: reset mid-play");
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b0, 0, 0);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 4, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_mole",         32'(mole), 0);
    checkOutput("abort_time_left",    32'(time_left), 0);
    checkOutput("abort_score_enable", 32'(score_enable), 0);
    checkOutput("abort_hit_pulse",    32'(hit_pulse), 0);
    checkOutput("abort_score_clear",  32'(score_clear), 0);
    checkOutput("abort_game_over",    32'(game_over), 0);
    btn = 4'b0000;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, 4, 0);
    @(negedge clk);
    checkOutput("idle_after_reset_time", 32'(time_left), 0);
    checkOutput("idle_after_reset_over", 32'(game_over), 0);
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b0, 0, 0);
    @(negedge clk);
    checkOutput("idle_start_clear", 32'(score_clear), 1);
    applyStimulus(1'b0, 0, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Param NUM_MOLES, default 4, number of mole positions; power of two, 2..8.
REQ-002 Param TICK_DIV, default 50_000_000, clk cycles per game tick.
REQ-003 Param GAME_TICKS, default 30, game length in ticks (1..255).
REQ-004 Param MOLE_TICKS, default 2, ticks a mole stays up (1..15).
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle pulse, already debounced.
REQ-008 btn  in  NUM_MOLES  whack pulses, one bit per mole, single-cycle each.
REQ-009 mole  out  NUM_MOLES  one-hot active mole; all-zero means no mole is up.
REQ-010 score_clear  out  1  one-cycle clear strobe to the score counter.
REQ-011 score_enable  out  1  score counter enable.
REQ-012 hit_pulse  out  1  one-cycle strobe per accepted hit.
REQ-013 time_left  out  8  remaining game ticks.
REQ-014 game_over  out  1  high while in state OVER.

Function
REQ-015 FSM states: IDLE, ARM, PLAY, OVER.
REQ-016 IDLE or OVER with start=1 -> ARM; ARM -> PLAY unconditionally after 1 cycle.
REQ-017 In ARM: score_clear=1 for exactly that cycle, time_left loaded with GAME_TICKS, prescaler set to 0, mole cleared.
REQ-018 start is ignored in ARM and PLAY.
REQ-019 Prescaler counts 0..TICK_DIV-1 only in PLAY; tick is asserted for the cycle in which count==TICK_DIV-1, after which the count wraps to 0.
REQ-020 On tick in PLAY: time_left decrements by 1; tick with time_left==1 -> OVER, time_left=0, mole cleared.
REQ-021 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seeded 0xA5 at reset; it advances every cycle regardless of state and never reaches 0.
REQ-022 In PLAY, any cycle with mole==0 and no hit accepted: on the next edge, mole = one-hot of lfsr[log2(NUM_MOLES)-1:0] and mole_timer = MOLE_TICKS.
REQ-023 mole_timer decrements on each tick while a mole is up; a tick at mole_timer==1 clears mole (a miss, which has no score effect).
REQ-024 Hit accepted when state==PLAY and (btn & mole)!=0: on the next edge, hit_pulse=1 for one cycle and mole is cleared.
REQ-025 Buttons with (btn & mole)==0 are ignored; multiple bits set counts as at most one hit.
REQ-026 Hit and mole expiry in the same cycle: the hit wins.
REQ-027 Hit in the same cycle as the game-ending tick: the hit is accepted, hit_pulse is asserted in the first OVER cycle, and score_enable covers it.
REQ-028 score_enable is registered: high throughout PLAY and for exactly one cycle after leaving PLAY.
REQ-029 No respawn between a clear and the next spawn: at least one cycle with mole==0.
REQ-030 mole is always zero or one-hot; it is zero outside PLAY.

Reset
REQ-031 rst_n low asynchronously sets: state=IDLE, mole=0, score_clear=0, score_enable=0, hit_pulse=0, time_left=0, game_over=0, prescaler=0, mole_timer=0, LFSR=0xA5.
REQ-032 Reset mid-PLAY aborts the game; after release the block waits in IDLE for start.

Structure
REQ-033 Shared package game_pkg holds the state encoding (IDLE=0, ARM=1, PLAY=2, OVER=3), LFSR_SEED=8'hA5 and the LFSR tap mask.
REQ-034 The LFSR is a sub-module lfsr8 (clk, rst_n, out[7:0]); everything else stays in game_sequencer.

Verification (TICK_DIV=4, GAME_TICKS=10, MOLE_TICKS=3, NUM_MOLES=4)
REQ-035 Reset, then start pulse -> score_clear=1 one cycle later, then PLAY with time_left=10; game_over=1 and time_left=0 exactly 40 cycles after entering PLAY.
REQ-036 Press btn matching mole 2 cycles after spawn -> hit_pulse=1 for one cycle, mole=0 for at least 1 cycle, then a new one-hot mole appears.
REQ-037 Hold no buttons -> each mole clears after 3 ticks (12 cycles ±prescaler phase); hit_pulse stays 0.
REQ-038 btn=4'b1111 with one mole up -> exactly one hit_pulse; btn on an inactive position -> no hit_pulse.
REQ-039 Hit coincident with the final tick -> hit_pulse and score_enable both high in the first OVER cycle; score_enable low thereafter.
REQ-040 Assert rst_n=0 mid-PLAY -> all outputs zero immediately; start during OVER -> new game with score_clear pulse.
